// File: rtl/led_fader.sv
// led_fader: fades an LED up and down in response to an on/off request.
// Four-state FSM (OFF, UP, ON, DOWN). A step counter paces 1-LSB brightness steps,
// and a free-running PWM counter drives LED_OUT.
// Optional build macro LED_FADER_GAMMA_EN: maps brightness to a gamma-corrected duty
// using (BRIGHT*BRIGHT + 255) >> 8. Without the macro, duty equals BRIGHT.
module led_fader #(
    parameter int unsigned STEP_CYCLES = 195313
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LED_IN,
    output logic       LED_OUT,
    output logic [7:0] BRIGHT,
    output logic       BUSY
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {StOff, StUp, StOn, StDown} state_e;

    state_e           state_q, state_d;
    logic [StepW-1:0] step_q, step_d;
    logic [7:0]       bright_q, bright_d;
    logic [7:0]       pwm_q, pwm_d;
    logic             led_q, led_d;
    logic [7:0]       duty;
    logic             step_done;
    logic             fading;

    assign step_done = (step_q == StepLast);
    assign fading    = (state_q == StUp) || (state_q == StDown);

`ifdef LED_FADER_GAMMA_EN
    logic [15:0] gamma_sq;
    // Rounded-up square law keeps duty nonzero for any nonzero brightness.
    always_comb gamma_sq = ({8'd0, bright_q} * {8'd0, bright_q}) + 16'd255;
    assign duty = gamma_sq[15:8];
`else
    assign duty = bright_q;
`endif

    // State register plus datapath registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= StOff;
            step_q   <= '0;
            bright_q <= 8'd0;
            pwm_q    <= 8'd0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
        end
    end

    // Next-state logic; leaving UP/DOWN coincides with the step that hits the end stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff: begin
                if (LED_IN) state_d = StUp;
            end
            StUp: begin
                if (!LED_IN) begin
                    state_d = StDown;
                end else if (bright_q == 8'd255 || (step_done && bright_q == 8'd254)) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (!LED_IN) state_d = StDown;
            end
            StDown: begin
                if (LED_IN) begin
                    state_d = StUp;
                end else if (bright_q == 8'd0 || (step_done && bright_q == 8'd1)) begin
                    state_d = StOff;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Step pacing and saturating brightness; a reversal restarts pacing with no step.
    always_comb begin
        bright_d = bright_q;
        if (state_q == StUp && LED_IN && step_done && bright_q != 8'd255) begin
            bright_d = bright_q + 8'd1;
        end else if (state_q == StDown && !LED_IN && step_done && bright_q != 8'd0) begin
            bright_d = bright_q - 8'd1;
        end

        if (fading && state_d == state_q && !step_done) begin
            step_d = step_q + 1'b1;
        end else begin
            step_d = '0;
        end
    end

    // PWM period of 255 cycles so duty 255 keeps the LED permanently on.
    always_comb begin
        pwm_d = (pwm_q == 8'd254) ? 8'd0 : pwm_q + 8'd1;
        led_d = (pwm_q < duty);
    end

    // Output decode of the state register.
    always_comb begin
        BUSY = 1'b0;
        unique case (state_q)
            StUp, StDown: BUSY = 1'b1;
            default:      BUSY = 1'b0;
        endcase
        BRIGHT  = bright_q;
        LED_OUT = led_q;
    end

endmodule
